// File: rtl/otter_intc_if.sv
// Data-memory bus slave port of the interrupt controller: read/write strobes
// already qualified by the address decoder, byte enables, offset and data.
interface otter_intc_if;
    logic        bus_r_en;
    logic        bus_w_en;
    logic [3:0]  bus_w_strb;
    logic [7:0]  bus_addr;
    logic [31:0] bus_w_data;
    logic [31:0] bus_r_data;

    modport master (
        output bus_r_en, bus_w_en, bus_w_strb, bus_addr, bus_w_data,
        input  bus_r_data
    );

    modport slave (
        input  bus_r_en, bus_w_en, bus_w_strb, bus_addr, bus_w_data,
        output bus_r_data
    );
endinterface

// File: rtl/otter_intc.sv
// Interrupt controller for otter_mcu: synchronizes raw sources, latches them as
// edge or level events, masks with ENABLE and INSERVICE, and offers a
// claim/complete handshake on the data-memory bus with one-cycle read latency.
module otter_intc #(
    parameter int NUM_SRC = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        i_irq_src,
    otter_intc_if.slave        bus,
    output logic [31:0]        o_intrpt
);

    // Bits at and above NUM_SRC never hold state.
    localparam logic [31:0] SRC_MASK =
        (NUM_SRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_SRC) - 32'd1);

    localparam logic [2:0] OFF_PENDING   = 3'd0;
    localparam logic [2:0] OFF_ENABLE    = 3'd1;
    localparam logic [2:0] OFF_EDGE      = 3'd2;
    localparam logic [2:0] OFF_CLAIM     = 3'd3;
    localparam logic [2:0] OFF_INSERVICE = 3'd4;

    // Lowest set bit of v as id+1, or 0 when v is empty.
    function automatic logic [5:0] f_claim_val(input logic [31:0] v);
        logic [5:0] r;
        r = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 6'(i + 1);
        end
        return r;
    endfunction

    // Synchronizer chain: s1, s2 and the delayed s2 used for edge detection.
    logic [31:0] r_s1_p0;
    logic [31:0] r_s2_p1;
    logic [31:0] r_s2d_p2;

    logic [31:0] r_pending;
    logic [31:0] r_enable;
    logic [31:0] r_edge;
    logic [31:0] r_inservice;
    logic [31:0] r_rdata;
    logic [31:0] r_intrpt;

    logic [2:0]  w_off;
    logic [31:0] w_bmask;
    logic        w_wr_pend;
    logic        w_wr_en;
    logic        w_wr_edge;
    logic        w_rd_claim;
    logic        w_complete;
    logic [31:0] w_elig;
    logic [5:0]  w_claim_val;
    logic [31:0] w_claim_oh;
    logic [31:0] w_cmp_oh;
    logic [31:0] w_w1c;
    logic [31:0] w_rise;
    logic [31:0] w_pend_edge;
    logic [31:0] w_enable_nxt;
    logic [31:0] w_edge_nxt;
    logic [31:0] w_edge_chg;
    logic [31:0] w_pending_nxt;
    logic [31:0] w_inservice_nxt;
    logic [31:0] w_rd_mux;
    logic        w_unused_addr;

    // Only the word offset decodes; the remaining address bits are don't-care.
    assign w_off         = bus.bus_addr[4:2];
    assign w_unused_addr = ^{bus.bus_addr[7:5], bus.bus_addr[1:0]};

    assign w_bmask = {{8{bus.bus_w_strb[3]}}, {8{bus.bus_w_strb[2]}},
                      {8{bus.bus_w_strb[1]}}, {8{bus.bus_w_strb[0]}}};

    assign w_wr_pend  = bus.bus_w_en && (w_off == OFF_PENDING);
    assign w_wr_en    = bus.bus_w_en && (w_off == OFF_ENABLE);
    assign w_wr_edge  = bus.bus_w_en && (w_off == OFF_EDGE);
    assign w_rd_claim = bus.bus_r_en && (w_off == OFF_CLAIM);

    // Claim picks the lowest-numbered eligible source from pre-write state.
    assign w_elig      = r_pending & r_enable & ~r_inservice;
    assign w_claim_val = f_claim_val(w_elig);
    assign w_claim_oh  = (w_rd_claim && (w_claim_val != 6'd0))
                         ? (32'd1 << (w_claim_val - 6'd1)) : 32'd0;

    // A complete only touches a source that is actually in service, so it can
    // never collide with a claim issued in the same cycle.
    assign w_complete = bus.bus_w_en && (w_off == OFF_CLAIM) && bus.bus_w_strb[0]
                        && (bus.bus_w_data != 32'd0)
                        && (bus.bus_w_data <= 32'(NUM_SRC));
    assign w_cmp_oh   = w_complete ? ((32'd1 << (bus.bus_w_data - 32'd1)) & r_inservice)
                                   : 32'd0;

    assign w_enable_nxt = w_wr_en
        ? (((r_enable & ~w_bmask) | (bus.bus_w_data & w_bmask)) & SRC_MASK) : r_enable;
    assign w_edge_nxt   = w_wr_edge
        ? (((r_edge & ~w_bmask) | (bus.bus_w_data & w_bmask)) & SRC_MASK) : r_edge;
    assign w_edge_chg   = w_edge_nxt ^ r_edge;

    // Edge sources: a new rising edge beats any clear landing on the same edge.
    assign w_w1c       = w_wr_pend ? (bus.bus_w_data & w_bmask) : 32'd0;
    assign w_rise      = r_s2_p1 & ~r_s2d_p2;
    assign w_pend_edge = (r_pending & ~(w_w1c | w_claim_oh)) | w_rise;

    // Level sources simply track s2; reclassifying a source drops its pending bit.
    assign w_pending_nxt = ((r_edge & w_pend_edge) | (~r_edge & r_s2_p1))
                           & ~w_edge_chg & SRC_MASK;

    assign w_inservice_nxt = ((r_inservice & ~w_cmp_oh) | w_claim_oh) & SRC_MASK;

    // Read mux over pre-write register values.
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            OFF_PENDING:   w_rd_mux = r_pending;
            OFF_ENABLE:    w_rd_mux = r_enable;
            OFF_EDGE:      w_rd_mux = r_edge;
            OFF_CLAIM:     w_rd_mux = {26'd0, w_claim_val};
            OFF_INSERVICE: w_rd_mux = r_inservice;
            default:       w_rd_mux = 32'd0;
        endcase
    end

    // Two-flop synchronizer plus the delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_p0  <= 32'd0;
            r_s2_p1  <= 32'd0;
            r_s2d_p2 <= 32'd0;
        end else begin
            r_s1_p0  <= i_irq_src & SRC_MASK;
            r_s2_p1  <= r_s1_p0;
            r_s2d_p2 <= r_s2_p1;
        end
    end

    // Architectural registers: pending, enable, edge and in-service masks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 32'd0;
            r_enable    <= 32'd0;
            r_edge      <= 32'd0;
            r_inservice <= 32'd0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_enable    <= w_enable_nxt;
            r_edge      <= w_edge_nxt;
            r_inservice <= w_inservice_nxt;
        end
    end

    // Registered bus read data (held when idle) and interrupt vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= 32'd0;
            r_intrpt <= 32'd0;
        end else begin
            if (bus.bus_r_en) r_rdata <= w_rd_mux;
            r_intrpt <= w_elig;
        end
    end

    assign bus.bus_r_data = r_rdata;
    assign o_intrpt       = r_intrpt;

endmodule

// File: tb/tb_otter_intc.sv
// Bench for otter_intc: directed scenarios with constant expectations, then a
// randomized run checked every cycle against a bit-level behavioural model.
module tb_otter_intc;

    localparam int NSRC = 32;

    logic        clk;
    logic        rst;
    logic [31:0] irq;
    logic [31:0] intrpt;

    int checks;
    int failures;

    otter_intc_if bif();

    otter_intc #(.NUM_SRC(NSRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_irq_src (irq),
        .bus       (bif),
        .o_intrpt  (intrpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_s1, m_s2, m_s2d, m_pend, m_en, m_edge, m_insv, m_rd, m_int;

    // Advance one clock: compute the model's next state from the inputs the DUT
    // is about to sample, wait for the edge, then commit.
    task automatic tick();
        logic [31:0] n_s1, n_s2, n_s2d, n_pend, n_en, n_edge, n_insv, n_rd, n_int;
        int          claim;
        int          off;
        logic        bsel;
        n_s1 = 0; n_s2 = 0; n_s2d = 0; n_pend = 0; n_en = 0; n_edge = 0;
        n_insv = 0; n_rd = 0; n_int = 0;
        if (!rst) begin
            off   = int'(bif.bus_addr[4:2]);
            claim = -1;
            for (int i = 0; i < NSRC; i++) begin
                if (m_pend[i] && m_en[i] && !m_insv[i]) begin
                    n_int[i] = 1'b1;
                    if (claim < 0 && bif.bus_r_en && off == 3) claim = i;
                end
            end
            n_rd = m_rd;
            if (bif.bus_r_en) begin
                case (off)
                    0: n_rd = m_pend;
                    1: n_rd = m_en;
                    2: n_rd = m_edge;
                    3: n_rd = (claim < 0) ? 32'd0 : 32'(claim + 1);
                    4: n_rd = m_insv;
                    default: n_rd = 32'd0;
                endcase
            end
            for (int i = 0; i < NSRC; i++) begin
                bsel      = bif.bus_w_strb[i / 8];
                n_s1[i]   = irq[i];
                n_s2[i]   = m_s1[i];
                n_s2d[i]  = m_s2[i];
                n_en[i]   = (bif.bus_w_en && off == 1 && bsel) ? bif.bus_w_data[i] : m_en[i];
                n_edge[i] = (bif.bus_w_en && off == 2 && bsel) ? bif.bus_w_data[i] : m_edge[i];
                if (n_edge[i] != m_edge[i])
                    n_pend[i] = 1'b0;
                else if (m_edge[i]) begin
                    if (m_s2[i] && !m_s2d[i])
                        n_pend[i] = 1'b1;
                    else if (claim == i || (bif.bus_w_en && off == 0 && bsel && bif.bus_w_data[i]))
                        n_pend[i] = 1'b0;
                    else
                        n_pend[i] = m_pend[i];
                end else
                    n_pend[i] = m_s2[i];
                n_insv[i] = m_insv[i];
                if (bif.bus_w_en && off == 3 && bif.bus_w_strb[0] && bif.bus_w_data == 32'(i + 1))
                    n_insv[i] = 1'b0;
                if (claim == i)
                    n_insv[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_s1 = n_s1; m_s2 = n_s2; m_s2d = n_s2d; m_pend = n_pend; m_en = n_en;
        m_edge = n_edge; m_insv = n_insv; m_rd = n_rd; m_int = n_int;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bif.bus_w_en   = 1'b1;
        bif.bus_addr   = a;
        bif.bus_w_data = d;
        bif.bus_w_strb = s;
        tick();
        bif.bus_w_en   = 1'b0;
        bif.bus_w_strb = 4'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bif.bus_r_en = 1'b1;
        bif.bus_addr = a;
        tick();
        bif.bus_r_en = 1'b0;
        d = bif.bus_r_data;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        irq = 32'hFFFF_FFFF;
        ticks(3);
        bif.bus_r_en = 1'b1;
        bif.bus_addr = 8'h00;
        tick();
        bif.bus_r_en = 1'b0;
        checks++;
        if (intrpt !== 32'd0) begin
            failures++; $display("FAIL reset_intrpt got=%h want=%h", intrpt, 32'd0);
        end
        checks++;
        if (bif.bus_r_data !== 32'd0) begin
            failures++; $display("FAIL reset_rdata got=%h want=%h", bif.bus_r_data, 32'd0);
        end
        rst = 1'b0;
        ticks(4);
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL reset_pending_level got=%h want=%h", d, 32'hFFFF_FFFF);
        end
        checks++;
        if (intrpt !== 32'd0) begin
            failures++; $display("FAIL reset_disabled_intrpt got=%h want=%h", intrpt, 32'd0);
        end
    endtask

    task automatic test_level_claim();
        logic [31:0] d;
        irq = 32'd0;
        ticks(4);
        bus_write(8'h04, 32'h0000_0030, 4'hF);
        bus_write(8'h08, 32'h0000_0000, 4'hF);
        ticks(2);
        irq = 32'h0000_0010;
        ticks(3);
        checks++;
        if (intrpt !== 32'd0) begin
            failures++; $display("FAIL level_latency_early got=%h want=%h", intrpt, 32'd0);
        end
        tick();
        checks++;
        if (intrpt !== 32'h10) begin
            failures++; $display("FAIL level_latency got=%h want=%h", intrpt, 32'h10);
        end
        bus_read(8'h0C, d);
        checks++;
        if (d !== 32'd5) begin
            failures++; $display("FAIL level_claim got=%h want=%h", d, 32'd5);
        end
        bus_read(8'h10, d);
        checks++;
        if (d !== 32'h10) begin
            failures++; $display("FAIL level_inservice got=%h want=%h", d, 32'h10);
        end
        checks++;
        if (intrpt !== 32'd0) begin
            failures++; $display("FAIL level_masked got=%h want=%h", intrpt, 32'd0);
        end
        bus_write(8'h0C, 32'd5, 4'hF);
        tick();
        checks++;
        if (intrpt !== 32'h10) begin
            failures++; $display("FAIL level_reraise got=%h want=%h", intrpt, 32'h10);
        end
    endtask

    task automatic test_edge_priority();
        logic [31:0] d;
        logic [31:0] want [3];
        want[0] = 32'd1; want[1] = 32'd8; want[2] = 32'd0;
        irq = 32'd0;
        bus_write(8'h04, 32'h81, 4'hF);
        bus_write(8'h08, 32'h81, 4'hF);
        ticks(3);
        irq = 32'h81;
        ticks(2);
        irq = 32'd0;
        ticks(4);
        for (int k = 0; k < 3; k++) begin
            bus_read(8'h0C, d);
            checks++;
            if (d !== want[k]) begin
                failures++; $display("FAIL edge_claim%0d got=%h want=%h", k, d, want[k]);
            end
        end
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'd0) begin
            failures++; $display("FAIL edge_pending got=%h want=%h", d, 32'd0);
        end
        bus_read(8'h10, d);
        checks++;
        if (d !== 32'h81) begin
            failures++; $display("FAIL edge_inservice got=%h want=%h", d, 32'h81);
        end
        bus_write(8'h0C, 32'd1, 4'h1);
        bus_write(8'h0C, 32'd8, 4'h1);
        bus_read(8'h10, d);
        checks++;
        if (d !== 32'd0) begin
            failures++; $display("FAIL edge_complete got=%h want=%h", d, 32'd0);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        bus_write(8'h08, 32'h08, 4'hF);
        bus_write(8'h04, 32'h08, 4'hF);
        irq = 32'h08;
        ticks(2);
        irq = 32'd0;
        ticks(3);
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h08) begin
            failures++; $display("FAIL w1c_setup got=%h want=%h", d, 32'h08);
        end
        irq = 32'h08;
        ticks(2);
        bus_write(8'h00, 32'h08, 4'hF);
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'h08) begin
            failures++; $display("FAIL w1c_race got=%h want=%h", d, 32'h08);
        end
        bus_write(8'h00, 32'h08, 4'hF);
        bus_read(8'h00, d);
        checks++;
        if (d !== 32'd0) begin
            failures++; $display("FAIL w1c_clear got=%h want=%h", d, 32'd0);
        end
        irq = 32'd0;
        ticks(2);
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        bus_write(8'h04, 32'd0, 4'hF);
        bus_write(8'h04, 32'hFFFF_FFFF, 4'b0010);
        bus_read(8'h04, d);
        checks++;
        if (d !== 32'h0000_FF00) begin
            failures++; $display("FAIL strb_enable got=%h want=%h", d, 32'h0000_FF00);
        end
        bus_read(8'h07, d);
        checks++;
        if (d !== 32'h0000_FF00) begin
            failures++; $display("FAIL addr_lowbits got=%h want=%h", d, 32'h0000_FF00);
        end
        irq = 32'h200;
        ticks(4);
        bus_read(8'h0C, d);
        checks++;
        if (d !== 32'd10) begin
            failures++; $display("FAIL strb_claim got=%h want=%h", d, 32'd10);
        end
        bus_write(8'h0C, 32'd0, 4'hF);
        bus_write(8'h0C, 32'd33, 4'hF);
        bus_write(8'h0C, 32'd4, 4'hF);
        bus_write(8'h0C, 32'd10, 4'hE);
        bus_read(8'h10, d);
        checks++;
        if (d !== 32'h200) begin
            failures++; $display("FAIL illegal_complete got=%h want=%h", d, 32'h200);
        end
        bus_write(8'h1C, 32'hFFFF_FFFF, 4'hF);
        bus_read(8'h1C, d);
        checks++;
        if (d !== 32'd0) begin
            failures++; $display("FAIL reserved_read got=%h want=%h", d, 32'd0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_read(8'h10, d);
        checks++;
        if (d !== 32'd0) begin
            failures++; $display("FAIL rstmid_inservice got=%h want=%h", d, 32'd0);
        end
        ticks(4);
        checks++;
        if (intrpt !== 32'd0) begin
            failures++; $display("FAIL rstmid_intrpt_low got=%h want=%h", intrpt, 32'd0);
        end
        bus_write(8'h04, 32'h200, 4'hF);
        checks++;
        if (intrpt !== 32'd0) begin
            failures++; $display("FAIL rstmid_intrpt_early got=%h want=%h", intrpt, 32'd0);
        end
        tick();
        checks++;
        if (intrpt !== 32'h200) begin
            failures++; $display("FAIL rstmid_intrpt_rise got=%h want=%h", intrpt, 32'h200);
        end
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        for (int c = 0; c < 600; c++) begin
            irq ^= ($urandom & $urandom & $urandom);
            rst            = ($urandom_range(0, 199) == 0);
            bif.bus_r_en   = ($urandom_range(0, 2) == 0);
            bif.bus_w_en   = ($urandom_range(0, 2) == 0);
            bif.bus_addr   = 8'($urandom);
            bif.bus_w_strb = 4'($urandom);
            if (bif.bus_addr[4:2] == 3'd3)
                bif.bus_w_data = 32'($urandom_range(0, 34));
            else
                bif.bus_w_data = $urandom;
            tick();
            checks++;
            if (intrpt !== m_int) begin
                failures++;
                if (shown < 10) $display("FAIL rand_intrpt cyc=%0d got=%h want=%h", c, intrpt, m_int);
                shown++;
            end
            checks++;
            if (bif.bus_r_data !== m_rd) begin
                failures++;
                if (shown < 10) $display("FAIL rand_rdata cyc=%0d got=%h want=%h", c, bif.bus_r_data, m_rd);
                shown++;
            end
        end
        rst          = 1'b0;
        bif.bus_r_en = 1'b0;
        bif.bus_w_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_s1 = 0; m_s2 = 0; m_s2d = 0; m_pend = 0; m_en = 0;
        m_edge = 0; m_insv = 0; m_rd = 0; m_int = 0;
        rst            = 1'b1;
        irq            = 32'd0;
        bif.bus_r_en   = 1'b0;
        bif.bus_w_en   = 1'b0;
        bif.bus_w_strb = 4'h0;
        bif.bus_addr   = 8'h00;
        bif.bus_w_data = 32'd0;
        test_reset();
        test_level_claim();
        test_edge_priority();
        test_w1c_race();
        test_strobes();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/otter_intc.md
# otter_intc

Memory-mapped interrupt controller that drives the `intrpt` vector of `otter_mcu`. It synchronizes external interrupt sources and latches them as edge or level events, then gates them with enable and in-service masks. It exposes a claim/complete handshake to firmware through a slave port on the data-memory bus, placed behind the address decoder beside program memory. Read latency is one cycle, matching the synchronous memory the core already talks to.

## Interface
- `NUM_SRC`, 32: number of interrupt sources, 1..32; bits at and above `NUM_SRC` read 0 and are never set.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `irq_src` in 32: raw asynchronous interrupt sources.
- `bus_r_en` in 1: register read strobe, already qualified by the address decoder.
- `bus_w_en` in 1: register write strobe, already qualified by the address decoder.
- `bus_w_strb` in 4: byte write enables.
- `bus_addr` in 8: byte offset; only bits [4:2] decode, bits [1:0] are ignored.
- `bus_w_data` in 32: write data.
- `bus_r_data` out 32: registered read data.
- `intrpt` out 32: registered interrupt vector to `otter_mcu`.

## Operation
- Sources pass through a 2-flop synchronizer, `s1` then `s2`. Edge detection compares `s2` with a registered copy `s2_d`.
- Register map by word offset:
  - 0x00 PENDING: read; write-1-to-clear, edge sources only.
  - 0x04 ENABLE: read/write.
  - 0x08 EDGE: read/write; 1 = rising-edge source, 0 = level source.
  - 0x0C CLAIM: read = claim; write = complete.
  - 0x10 INSERVICE: read only.
  - 0x14 to 0x1C: read 0; writes ignored.
- Writes to ENABLE and EDGE honor `bus_w_strb` per byte. W1C writes to PENDING honor `bus_w_strb`. A complete write needs `bus_w_strb[0]`.
- Pending, edge source `i`: set when `s2[i] & ~s2_d[i]`. Cleared by W1C or by a claim of `i`. If a set and a clear land in the same cycle, set wins.
- Pending, level source `i`: `pending[i]` equals `s2[i]` every cycle. W1C has no effect.
- Changing EDGE for a source clears that source's pending bit on the same edge.
- Eligible mask: `elig = pending & enable & ~inservice`. `intrpt` is registered from `elig`.
- Claim: `bus_r_en` with offset 0x0C.
  - Returns `id+1` in bits [5:0], where `id` is the lowest-numbered set bit of `elig`; bits [31:6] are 0.
  - Returns 0 if `elig` is empty.
  - On a nonzero return, sets `inservice[id]`. Also clears `pending[id]` if the source is edge-type.
- Complete: `bus_w_en` with offset 0x0C, value `v` in 1..`NUM_SRC`, clears `inservice[v-1]`. Values 0 or greater than `NUM_SRC` are ignored, as is a source not currently in service.
- Any other read: `bus_r_data` takes the addressed register value at the edge. When `bus_r_en` is low, `bus_r_data` holds its last value.
- Read and write to the same register in one cycle: the read returns the pre-write value.
- A claim read and a complete write in the same cycle: the claim is evaluated on pre-complete state, then both updates apply.

## Timing
- Reset values: every register, synchronizer flop, `s2_d`, `bus_r_data` and `intrpt` = 0.
- Reset has priority over all bus activity in the same cycle.
- Source latency: `irq_src[i]` is first sampled high at edge k.
  - `s2` is high after edge k+1.
  - `pending` is set after edge k+2.
  - `intrpt[i]` is high after edge k+3.
- Edge pulses shorter than one clock period may be missed. That is by design.
- Bus reads: data is valid the cycle after `bus_r_en`, one-cycle latency. Claim side effects apply at the same edge that registers `bus_r_data`.
- Masking latency: a write to ENABLE, a W1C, a claim or a complete updates `intrpt` one edge after the register update, two edges after the bus strobe.
- No wait states. Back-to-back reads and writes are allowed every cycle.
- Level source deasserting while in service: pending drops and `intrpt` stays 0. A complete with the level still high re-raises `intrpt` one edge after the INSERVICE update.

## Test plan
- Reset with `irq_src`=0xFFFFFFFF held high: all outputs are 0 during reset.
- After release, with EDGE=0 and ENABLE=0: PENDING reads 0xFFFFFFFF and `intrpt` stays 0.
- Level claim:
  - Set ENABLE=0x0000_0030 and EDGE=0, then raise `irq_src[4]`: `intrpt`=0x10 exactly 3 edges after the first sample.
  - Read CLAIM: returns 5; INSERVICE=0x10; `intrpt`=0.
  - Write CLAIM=5 with `irq_src[4]` still high: `intrpt` returns to 0x10.
- Edge priority: set EDGE=ENABLE=0x81, then pulse sources 0 and 7 high for 2 cycles together.
  - First claim returns 1, second returns 8, third returns 0.
  - PENDING=0 and INSERVICE=0x81.
- W1C race: hold edge source 3 pending and enabled, then write PENDING=0x08 in the same cycle a new rising edge reaches `s2`: PENDING[3] stays 1.
- Strobes and illegal completes:
  - Write ENABLE=0xFFFFFFFF with `bus_w_strb`=0b0010: ENABLE reads 0x0000FF00.
  - Complete values 0, 33 and an id not in service: INSERVICE is unchanged.
  - Reads of offset 0x1C return 0.
- Reset mid-service: claim a source, then assert `rst` for 1 cycle while that source's level stays high.
  - INSERVICE=0.
  - `intrpt` is 0 until ENABLE is rewritten, then rises 2 edges after that write.
